// File: rtl/uss_pkg.sv
// Shared types and constants for the USS scan controller and its raster counter.
package uss_pkg;

    localparam int USS_GRID    = 8;
    localparam int USS_NSAMP   = 64;
    localparam int USS_SEL_W   = 16;
    localparam int USS_COORD_W = 3;
    localparam int USS_LOAD_W  = 6;
    localparam int USS_LAT_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } uss_state_t;

endpackage

// File: rtl/uss_xy_cnt.sv
// Raster x/y coordinate counter: x inner, y outer, explicit wrap at GRID-1.
module uss_xy_cnt
    import uss_pkg::*;
#(
    parameter int GRID = USS_GRID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    output logic [USS_COORD_W-1:0] x,
    output logic [USS_COORD_W-1:0] y,
    output logic                   last
);

    localparam logic [USS_COORD_W-1:0] C_MAX = USS_COORD_W'(GRID - 1);

    logic [USS_COORD_W-1:0] r_x;
    logic [USS_COORD_W-1:0] r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (adv) begin
            if (r_x == C_MAX) begin
                r_x <= '0;
                r_y <= (r_y == C_MAX) ? '0 : r_y + USS_COORD_W'(1);
            end else begin
                r_x <= r_x + USS_COORD_W'(1);
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = (r_x == C_MAX) && (r_y == C_MAX);

endmodule

// File: rtl/uss_scan_ctrl.sv
// Sequencer for the USS neighbour-selection datapath: loads 64 samples, then
// scans every centre, capturing neighbor_sel after USS_LAT cycles.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting the 64 samples into uss_x_in
// ISSUE | coordinate presented, latency counter loaded
// WAIT  | waiting out the remaining datapath latency
// HOLD  | result presented, waiting for out_ready
module uss_scan_ctrl
    import uss_pkg::*;
#(
    parameter int USS_LAT = 1,
    parameter int GRID    = USS_GRID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [USS_COORD_W-1:0] in_data,
    output logic                   in_ready,
    output logic [USS_COORD_W-1:0] uss_x_in,
    output logic [USS_COORD_W-1:0] uss_x_c,
    output logic [USS_COORD_W-1:0] uss_y_c,
    input  logic [USS_SEL_W-1:0]   uss_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [USS_SEL_W-1:0]   out_sel,
    output logic [USS_COORD_W-1:0] out_x,
    output logic [USS_COORD_W-1:0] out_y,
    output logic                   busy,
    output logic                   done
);

    localparam logic [USS_LAT_W-1:0]  C_LAT_INIT = USS_LAT_W'(USS_LAT - 1);
    localparam logic [USS_LOAD_W-1:0] C_LOAD_END = USS_LOAD_W'(USS_NSAMP - 1);

    uss_state_t             r_state;
    logic [USS_LOAD_W-1:0]  r_load_cnt;
    logic [USS_LAT_W-1:0]   r_lat;
    logic                   r_in_ready;
    logic [USS_COORD_W-1:0] r_x_in;
    logic                   r_out_valid;
    logic [USS_SEL_W-1:0]   r_out_sel;
    logic [USS_COORD_W-1:0] r_out_x;
    logic [USS_COORD_W-1:0] r_out_y;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_adv;
    logic                   w_last;
    logic                   w_capture;
    logic [USS_COORD_W-1:0] w_x;
    logic [USS_COORD_W-1:0] w_y;

    // Coordinates move only on the handshake edge, so they stay stable from
    // ISSUE through the capture edge.
    assign w_adv = (r_state == S_HOLD) && r_out_valid && out_ready;

    uss_xy_cnt #(
        .GRID (GRID)
    ) u_xy_cnt (
        .clk  (clk),
        .rst  (rst),
        .adv  (w_adv),
        .x    (w_x),
        .y    (w_y),
        .last (w_last)
    );

    always_comb begin
        w_capture = 1'b0;
        if (r_state == S_ISSUE && USS_LAT == 1) begin
            w_capture = 1'b1;
        end
        if (r_state == S_WAIT && r_lat == USS_LAT_W'(1)) begin
            w_capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_lat       <= '0;
            r_in_ready  <= 1'b0;
            r_x_in      <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_load_cnt <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_x_in     <= in_data;
                        r_load_cnt <= r_load_cnt + USS_LOAD_W'(1);
                        if (r_load_cnt == C_LOAD_END) begin
                            r_state    <= S_ISSUE;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_lat   <= C_LAT_INIT;
                    r_state <= (USS_LAT == 1) ? S_HOLD : S_WAIT;
                end
                S_WAIT: begin
                    r_lat <= r_lat - USS_LAT_W'(1);
                    if (r_lat == USS_LAT_W'(1)) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_capture) begin
                r_out_sel   <= uss_sel;
                r_out_x     <= w_x;
                r_out_y     <= w_y;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign uss_x_in  = r_x_in;
    assign uss_x_c   = w_x;
    assign uss_y_c   = w_y;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_uss_scan_ctrl.sv
// Directed bench for uss_scan_ctrl with behavioural USS models at latency 1 and 4.
module tb_uss_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_data = 3'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, busy, done;
    logic [2:0]  uss_x_in, uss_x_c, uss_y_c, out_x, out_y;
    logic [15:0] uss_sel, out_sel;

    logic        in_ready4, out_valid4, busy4, done4;
    logic [2:0]  uss_x_in4, uss_x_c4, uss_y_c4, out_x4, out_y4;
    logic [15:0] uss_sel4, out_sel4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] f_sel(input logic [2:0] x, input logic [2:0] y);
        return {x, y, ~x, ~y, x ^ y, 1'b1};
    endfunction

    // USS model, latency 1: selection valid once the coordinate has been stable one cycle.
    assign uss_sel = f_sel(uss_x_c, uss_y_c);

    // USS model, latency 4: selection reflects the coordinate of three cycles earlier.
    logic [5:0] c4_d1 = 6'd0, c4_d2 = 6'd0, c4_d3 = 6'd0;
    always_ff @(posedge clk) begin
        c4_d1 <= {uss_x_c4, uss_y_c4};
        c4_d2 <= c4_d1;
        c4_d3 <= c4_d2;
    end
    assign uss_sel4 = f_sel(c4_d3[5:3], c4_d3[2:0]);

    uss_scan_ctrl #(.USS_LAT(1), .GRID(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .uss_x_in(uss_x_in), .uss_x_c(uss_x_c), .uss_y_c(uss_y_c),
        .uss_sel(uss_sel), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
    );

    uss_scan_ctrl #(.USS_LAT(4), .GRID(8)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .uss_x_in(uss_x_in4), .uss_x_c(uss_x_c4), .uss_y_c(uss_y_c4),
        .uss_sel(uss_sel4), .out_valid(out_valid4), .out_ready(out_ready), .out_sel(out_sel4),
        .out_x(out_x4), .out_y(out_y4), .busy(busy4), .done(done4)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_uss_x_in"},  32'(uss_x_in),  32'd0);
        check({tag, "_uss_x_c"},   32'(uss_x_c),   32'd0);
        check({tag, "_uss_y_c"},   32'(uss_y_c),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sel"},   32'(out_sel),   32'd0);
        check({tag, "_out_x"},     32'(out_x),     32'd0);
        check({tag, "_out_y"},     32'(out_y),     32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_busy4"},     32'(busy4),     32'd0);
        check({tag, "_out_valid4"},32'(out_valid4),32'd0);
    endtask

    task automatic load_cont(input int mult, input string tag);
        for (int i = 0; i < 64; i++) begin
            check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = 3'(i * mult + 1);
            tick();
            check({tag, "_xin"}, 32'(uss_x_in), 32'(in_data));
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int idx);
        check({tag, "_x"},   32'(out_x),   32'(idx % 8));
        check({tag, "_y"},   32'(out_y),   32'(idx / 8));
        check({tag, "_sel"}, 32'(out_sel), 32'(f_sel(3'(idx % 8), 3'(idx / 8))));
    endtask

    int cyc, res, res4, stall, done_cyc, done4_cyc, done_cnt, done4_cnt;
    logic [2:0] xin_exp;

    initial begin
        // ---- reset ----
        #2 rst = 1'b0;
        #2 check_zero("rst_async");
        tick(); tick();
        check_zero("rst_hold");
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        check("idle_in_valid_ignored", 32'(in_ready), 32'd0);

        // ---- frame 1: basic, both latencies side by side ----
        start = 1'b1; start4 = 1'b1;
        tick();
        start = 1'b0; start4 = 1'b0;
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_rdy4", 32'(in_ready4), 32'd1);
        load_cont(5, "f1");
        check("f1_rdy_after_load", 32'(in_ready), 32'd0);
        cyc = 64; res = 0; res4 = 0; done_cnt = 0; done4_cnt = 0;
        done_cyc = -1; done4_cyc = -1;
        while (cyc < 600 && !(done_cnt > 0 && done4_cnt > 0)) begin
            if (out_valid) begin
                check_result("f1_l1", res);
                res++;
            end
            if (out_valid4) begin
                check("f1_l4_x",   32'(out_x4),   32'(res4 % 8));
                check("f1_l4_y",   32'(out_y4),   32'(res4 / 8));
                check("f1_l4_sel", 32'(out_sel4), 32'(f_sel(3'(res4 % 8), 3'(res4 / 8))));
                res4++;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                check("f1_busy_at_done", 32'(busy), 32'd0);
            end
            if (done4) begin
                done4_cnt++; done4_cyc = cyc;
            end
            tick();
            cyc++;
        end
        check("f1_results",   32'(res),       32'd64);
        check("f1_results4",  32'(res4),      32'd64);
        check("f1_done_cyc",  32'(done_cyc),  32'd192);
        check("f1_done4_cyc", 32'(done4_cyc), 32'd384);
        check("f1_done_cnt",  32'(done_cnt),  32'd1);
        check("f1_done4_cnt", 32'(done4_cnt), 32'd1);

        // ---- frame 2: gapped load, ignored start/sample, back-pressure ----
        xin_exp = uss_x_in;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 127; i++) begin
            check("f2_rdy", 32'(in_ready), 32'd1);
            in_valid = (i % 2 == 0);
            in_data  = in_valid ? 3'(i * 3 + 1) : 3'(i + 2);
            if (in_valid) xin_exp = in_data;
            tick();
            check("f2_xin", 32'(uss_x_in), 32'(xin_exp));
        end
        in_valid = 1'b0;
        check("f2_issue_rdy",  32'(in_ready),  32'd0);
        check("f2_issue_busy", 32'(busy),      32'd1);
        check("f2_issue_ov",   32'(out_valid), 32'd0);
        check("f2_issue_xc",   32'(uss_x_c),   32'd0);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = xin_exp ^ 3'b101;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        check("f2_busy_start_rdy", 32'(in_ready), 32'd0);
        check("f2_sample_ignored", 32'(uss_x_in), 32'(xin_exp));
        cyc = 0; res = 0; stall = 0;
        while (!done && cyc < 1000) begin
            if (out_valid) begin
                check_result("f2", res);
                if (res == 19 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    res++;
                end
            end
            tick();
            cyc++;
        end
        check("f2_done_seen", 32'(done), 32'd1);
        check("f2_results",   32'(res),  32'd64);
        check("f2_stalls",    32'(stall),32'd5);
        check("f2_busy_done", 32'(busy), 32'd0);
        // back-to-back start in the done cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_rdy",  32'(in_ready), 32'd1);
        check("b2b_busy", 32'(busy),     32'd1);
        check("b2b_done", 32'(done),     32'd0);

        // ---- frame 3: reset at result (5,6) ----
        load_cont(3, "f3");
        cyc = 0; res = 0;
        while (cyc < 1000 && !(out_valid && out_x == 3'd5 && out_y == 3'd6)) begin
            if (out_valid) begin
                check_result("f3", res);
                res++;
            end
            tick();
            cyc++;
        end
        check("f3_before_rst", 32'(res), 32'd53);
        rst = 1'b0;
        #1 check_zero("rst_mid");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // ---- frame 4: normal frame after abort ----
        start = 1'b1;
        tick();
        start = 1'b0;
        load_cont(7, "f4");
        cyc = 0; res = 0;
        while (!done && cyc < 1000) begin
            if (out_valid) begin
                check_result("f4", res);
                res++;
            end
            tick();
            cyc++;
        end
        check("f4_done_seen", 32'(done), 32'd1);
        check("f4_results",   32'(res),  32'd64);
        check("f4_scan_cyc",  32'(cyc),  32'd128);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uss_scan_ctrl.md
# uss_scan_ctrl

Sequencing controller for the USS neighbour-selection datapath. It accepts a frame start, streams 64 3-bit samples into USS through `X_in`, then raster-scans every centre coordinate (X_c, Y_c) over the 8×8 grid. For each centre it waits the datapath latency, captures `neighbor_sel`, and presents it downstream with a valid/ready handshake. It sits between the frame source / result sink and a single USS instance, and owns all of that instance's inputs except clock and reset.

## Interface
- `USS_LAT`, default 1: cycles from a stable coordinate on `uss_x_c`/`uss_y_c` to a valid `uss_sel`; legal range 1..7.
- `GRID`, default 8: grid side; fixed at 8, since coordinates are 3 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset; also drives the USS instance reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `in_valid` in 1: sample on `in_data` is valid.
- `in_data` in 3: sample value.
- `in_ready` out 1: controller accepts a sample this cycle.
- `uss_x_in` out 3: registered sample forwarded to USS `X_in`.
- `uss_x_c` out 3: centre column to USS `X_c`.
- `uss_y_c` out 3: centre row to USS `Y_c`.
- `uss_sel` in 16: USS `neighbor_sel`.
- `out_valid` out 1: result held on the outputs.
- `out_ready` in 1: sink accepts the result.
- `out_sel` out 16: captured `neighbor_sel`.
- `out_x`, `out_y` out 3 each: centre coordinate the result belongs to.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, HOLD.
- **IDLE**
  - `start`=1 → LOAD; load counter cleared.
  - `in_valid` is ignored in IDLE.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid` cycle registers `in_data` into `uss_x_in` and increments the 6-bit load counter. Idle cycles leave `uss_x_in` unchanged.
  - When the 64th sample is accepted (counter 63 with `in_valid`), go to ISSUE with x=y=0.
- **ISSUE** (one cycle)
  - `uss_x_c`/`uss_y_c` already hold the current x, y.
  - Latency counter loads `USS_LAT`−1; go to WAIT, or to HOLD directly when `USS_LAT`=1.
- **WAIT**
  - Decrement the latency counter; at 0 go to HOLD.
- **Result capture**
  - On the entry edge into HOLD, `out_sel`←`uss_sel`, `out_x`←x, `out_y`←y, `out_valid`←1.
- **HOLD**
  - Outputs stay stable until `out_valid`&`out_ready`.
  - On acceptance: `out_valid`←0 and the scan advances. x increments; on x=7 it wraps to 0 and y increments.
  - If the accepted result was (7,7): `done`←1 for one cycle, go to IDLE, coordinates reset to 0.
  - Otherwise go to ISSUE.
- Scan order is raster: y outer, x inner. Results emerge in order (0,0),(1,0)…(7,0),(0,1)…(7,7).
- `start` while `busy`=1 is ignored; no queuing.
- `in_valid` outside LOAD is ignored and the sample is not consumed.
- Coordinate counters are 3-bit. Wrap is explicit, not via overflow of a wider counter.

## Timing
- **Reset values** (`rst`=0, asynchronous): state IDLE; `in_ready`=0; `uss_x_in`=0; `uss_x_c`=0; `uss_y_c`=0; `out_valid`=0; `out_sel`=0; `out_x`=0; `out_y`=0; `busy`=0; `done`=0.
- **Reset mid-frame:** immediate abort, no `done`. The next frame requires a new `start` and a full 64-sample load.
- **Output registers:** all outputs are registered. `in_ready` is decoded from the registered state, so it is glitch-free.
- **Start:** `start` at edge n → `in_ready`=1 from cycle n+1.
- **Sample forwarding:** a sample accepted at edge k appears on `uss_x_in` from cycle k+1.
- **Per-centre cost:** 1 (ISSUE) + `USS_LAT`−1 (WAIT) + 1 (HOLD, with immediate `out_ready`) = `USS_LAT`+1 cycles.
- **Frame length:** with no stalls and `USS_LAT`=1, 64 load cycles + 64×2 scan cycles.
- **Coordinate stability:** coordinates are held stable from ISSUE through the HOLD-entry capture edge. They change only on the edge where `out_valid`&`out_ready`.
- **Back-pressure:** `out_ready` low holds everything indefinitely; no result is lost or duplicated.
- **End of frame:** `done` is asserted on the cycle after the final handshake edge, with `busy`=0 in that same cycle. A `start` in the `done` cycle is accepted.

## Structure
- Shared package `uss_pkg`:
  - state encoding (IDLE=0 … HOLD=4, 3-bit);
  - `USS_GRID`=8, `USS_NSAMP`=64, `USS_SEL_W`=16, `USS_COORD_W`=3.
- Optional sub-module `uss_xy_cnt`: 3-bit x/y raster counter with `adv` input and `last` output.
- USS is instantiated by the parent, not inside this block.

## Test plan
- **Basic frame:** reset, `start`, 64 samples with continuous `in_valid`, `out_ready`=1, behavioural USS model with `USS_LAT`=1 → 64 results in raster order, each `out_sel` equal to the model value for (`out_x`,`out_y`); `done` pulses once, exactly 192 cycles after the first `in_ready`.
- **Gapped load:** `in_valid` toggling 1-0-1 → exactly 64 samples consumed; `uss_x_in` follows accepted values only; ISSUE is entered on the 64th acceptance.
- **Back-pressure:** `out_ready` low for 5 cycles at result (3,2) → `out_sel`, `out_x`=3, `out_y`=2 stable throughout; next result (4,2) appears only after the handshake; 64 results total.
- **Latency 4:** `USS_LAT`=4 → `uss_x_c`/`uss_y_c` stable 4 cycles before each capture; per-centre period 5 cycles with no stall.
- **Start while busy / back-to-back:** `start` during SCAN is ignored; `start` in the `done` cycle → LOAD begins next cycle.
- **Reset mid-scan:** `rst` low at result (5,6) → all outputs are 0 asynchronously; no `done`; a new frame completes normally afterwards.
